// File: rtl/mp_pkg.sv
// Shared types and frame constants for the track predictor and its history store.
package mp_pkg;

    localparam int          WIDTH      = 640;
    localparam int          HEIGHT     = 480;
    localparam logic [10:0] NOT_FOUND  = 11'd2023;
    localparam int          HIST_DEPTH = 5;

    typedef enum logic [1:0] {
        NOTRACK = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        COAST   = 2'd3
    } trk_state_t;

    typedef logic [10:0]        coord_t;
    typedef logic signed [11:0] vel_t;
    typedef logic signed [13:0] wide_t;

endpackage

// File: rtl/track_history.sv
// Per-axis centre history: newest at h[0], a push shifts older entries toward h[4].
module track_history
    import mp_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   clear,
    input  coord_t din,
    output coord_t h0,
    output coord_t h3,
    output coord_t h4
);

    coord_t hist [HIST_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
        end else if (push) begin
            hist[0] <= din;
            for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    // h[3] becomes the oldest entry once a push lands, so the updater needs it
    assign h0 = hist[0];
    assign h3 = hist[HIST_DEPTH-2];
    assign h4 = hist[HIST_DEPTH-1];

endmodule

// File: rtl/track_predictor.sv
// Per-frame bounding-box centre tracker with velocity estimate, coasting and clamped prediction.
module track_predictor
    import mp_pkg::*;
#(
    parameter int MIN_SIZE       = 4,
    parameter int MAX_MISS       = 8,
    parameter int LOG2_LOOKAHEAD = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [1:0][10:0]  i_up,
    input  logic [1:0][10:0]  i_left,
    input  logic [1:0][10:0]  i_right,
    input  logic [1:0][10:0]  i_down,
    output logic              o_valid,
    output logic              o_hit,
    output logic [10:0]       o_cx,
    output logic [10:0]       o_cy,
    output logic signed [11:0] o_vx,
    output logic signed [11:0] o_vy,
    output logic [10:0]       o_px,
    output logic [10:0]       o_py,
    output logic [1:0]        o_state,
    output logic              o_lost
);

    localparam int         MW        = $clog2(MAX_MISS + 1);
    localparam coord_t     MIN_SZ    = 11'(MIN_SIZE);
    localparam coord_t     X_MAX     = 11'(WIDTH - 1);
    localparam coord_t     Y_MAX     = 11'(HEIGHT - 1);
    localparam logic [2:0] FULL      = 3'(HIST_DEPTH);
    localparam logic [MW-1:0] MISS_LAST = MW'(MAX_MISS - 1);

    function automatic wide_t widen_c(input coord_t c);
        return $signed({3'b000, c});
    endfunction

    function automatic wide_t widen_v(input vel_t v);
        return {{2{v[11]}}, v};
    endfunction

    function automatic coord_t clamp_coord(input wide_t val, input coord_t hi);
        if (val < 14'sd0)             return '0;
        else if (val > widen_c(hi))   return hi;
        else                          return val[10:0];
    endfunction

    // arithmetic shift floors toward -inf for receding motion
    function automatic vel_t vel_of(input coord_t newest, input coord_t oldest);
        vel_t diff;
        diff = $signed({1'b0, newest}) - $signed({1'b0, oldest});
        return diff >>> 2;
    endfunction

    // ---- stage 0: capture the extreme points ----
    logic   vld_p0;
    coord_t up_y_p0, left_x_p0, right_x_p0, down_y_p0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) vld_p0 <= 1'b0;
        else          vld_p0 <= i_valid;
    end

    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            up_y_p0    <= i_up[0];
            left_x_p0  <= i_left[1];
            right_x_p0 <= i_right[1];
            down_y_p0  <= i_down[0];
        end
    end

    // ---- stage 1: detection, centre, history and state update ----
    coord_t      box_w, box_h, cx_meas, cy_meas;
    logic [11:0] sum_x, sum_y;
    logic        hit;

    assign box_w   = right_x_p0 - left_x_p0;
    assign box_h   = down_y_p0 - up_y_p0;
    assign sum_x   = {1'b0, left_x_p0} + {1'b0, right_x_p0};
    assign sum_y   = {1'b0, up_y_p0} + {1'b0, down_y_p0};
    assign cx_meas = sum_x[11:1];
    assign cy_meas = sum_y[11:1];
    assign hit = !((up_y_p0 == NOT_FOUND) || (left_x_p0 == NOT_FOUND) ||
                   (right_x_p0 < left_x_p0) || (down_y_p0 < up_y_p0) ||
                   (box_w < MIN_SZ) || (box_h < MIN_SZ));

    trk_state_t    state, state_n;
    logic [2:0]    count, count_n;
    logic [MW-1:0] miss_cnt, miss_n;
    vel_t          vx, vy, vx_n, vy_n;
    logic          push, clear, lost, calc_v;
    coord_t        din_x, din_y, synth_x, synth_y, pred_x, pred_y;
    coord_t        hx0, hx3, hy0, hy3, unused_hx4, unused_hy4;

    track_history u_hist_x (
        .clk(i_clk), .rst_n(i_rst_n), .push(push), .clear(clear),
        .din(din_x), .h0(hx0), .h3(hx3), .h4(unused_hx4)
    );

    track_history u_hist_y (
        .clk(i_clk), .rst_n(i_rst_n), .push(push), .clear(clear),
        .din(din_y), .h0(hy0), .h3(hy3), .h4(unused_hy4)
    );

    assign synth_x = clamp_coord(widen_c(hx0) + widen_v(vx), X_MAX);
    assign synth_y = clamp_coord(widen_c(hy0) + widen_v(vy), Y_MAX);

    always_comb begin
        state_n = state;
        count_n = count;
        miss_n  = miss_cnt;
        vx_n    = vx;
        vy_n    = vy;
        push    = 1'b0;
        clear   = 1'b0;
        lost    = 1'b0;
        calc_v  = 1'b0;
        din_x   = cx_meas;
        din_y   = cy_meas;
        if (vld_p0) begin
            case (state)
                NOTRACK: if (hit) begin
                    push    = 1'b1;
                    count_n = 3'd1;
                    state_n = ACQUIRE;
                end
                ACQUIRE: if (hit) begin
                    push    = 1'b1;
                    count_n = count + 3'd1;
                    if (count_n == FULL) begin
                        state_n = TRACK;
                        calc_v  = 1'b1;
                    end
                end else begin
                    clear   = 1'b1;
                    count_n = '0;
                    state_n = NOTRACK;
                end
                TRACK: begin
                    push = 1'b1;
                    if (hit) begin
                        calc_v = 1'b1;
                    end else begin
                        din_x   = synth_x;
                        din_y   = synth_y;
                        miss_n  = MW'(1);
                        state_n = COAST;
                    end
                end
                COAST: if (hit) begin
                    push    = 1'b1;
                    calc_v  = 1'b1;
                    miss_n  = '0;
                    state_n = TRACK;
                end else if (miss_cnt < MISS_LAST) begin
                    push   = 1'b1;
                    din_x  = synth_x;
                    din_y  = synth_y;
                    miss_n = miss_cnt + MW'(1);
                end else begin
                    clear   = 1'b1;
                    lost    = 1'b1;
                    miss_n  = '0;
                    count_n = '0;
                    state_n = NOTRACK;
                end
            endcase
        end
        if (calc_v) begin
            vx_n = vel_of(din_x, hx3);
            vy_n = vel_of(din_y, hy3);
        end
        if (state_n == NOTRACK) begin
            vx_n = '0;
            vy_n = '0;
        end
    end

    assign pred_x = clamp_coord(widen_c(din_x) + (widen_v(vx_n) <<< LOG2_LOOKAHEAD), X_MAX);
    assign pred_y = clamp_coord(widen_c(din_y) + (widen_v(vy_n) <<< LOG2_LOOKAHEAD), Y_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= NOTRACK;
            count    <= '0;
            miss_cnt <= '0;
            vx       <= '0;
            vy       <= '0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            miss_cnt <= miss_n;
            vx       <= vx_n;
            vy       <= vy_n;
        end
    end

    // ---- stage 2: output registers ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_hit   <= 1'b0;
            o_cx    <= '0;
            o_cy    <= '0;
            o_vx    <= '0;
            o_vy    <= '0;
            o_px    <= '0;
            o_py    <= '0;
            o_state <= '0;
            o_lost  <= 1'b0;
        end else begin
            o_valid <= vld_p0;
            o_lost  <= lost;
            if (vld_p0) begin
                o_hit   <= hit;
                o_state <= state_n;
                if (state_n == NOTRACK) begin
                    o_cx <= '0;
                    o_cy <= '0;
                    o_vx <= '0;
                    o_vy <= '0;
                    o_px <= '0;
                    o_py <= '0;
                end else begin
                    o_cx <= din_x;
                    o_cy <= din_y;
                    o_vx <= vx_n;
                    o_vy <= vy_n;
                    o_px <= pred_x;
                    o_py <= pred_y;
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{i_up[1], i_left[0], i_right[0], i_down[1], sum_x[0], sum_y[0]};

endmodule

// File: tb/tb_track_predictor.sv
// Randomized and directed bench for track_predictor against a queue-based tracking model.
`timescale 1ns/1ps
module tb_track_predictor;

    logic             clk = 1'b0;
    logic             i_rst_n;
    logic             i_valid;
    logic [1:0][10:0] i_up, i_left, i_right, i_down;
    logic             o_valid, o_hit, o_lost;
    logic [10:0]      o_cx, o_cy, o_px, o_py;
    logic signed [11:0] o_vx, o_vy;
    logic [1:0]       o_state;

    track_predictor dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
        .i_up(i_up), .i_left(i_left), .i_right(i_right), .i_down(i_down),
        .o_valid(o_valid), .o_hit(o_hit), .o_cx(o_cx), .o_cy(o_cy),
        .o_vx(o_vx), .o_vy(o_vy), .o_px(o_px), .o_py(o_py),
        .o_state(o_state), .o_lost(o_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        hit;
        logic [10:0] cx;
        logic [10:0] cy;
        logic [11:0] vx;
        logic [11:0] vy;
        logic [10:0] px;
        logic [10:0] py;
        logic [1:0]  state;
        logic        lost;
    } out_t;

    localparam int NF = 2023;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   f_uy[16], f_lx[16], f_rx[16], f_dy[16];
    out_t got[16];
    out_t exp_o;
    logic early_valid;

    // reference tracker state
    int m_state, m_cnt, m_miss, m_vx, m_vy;
    int hx[$], hy[$];

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic int floor_div4(input int d);
        return (d >= 0) ? d / 4 : -((-d + 3) / 4);
    endfunction

    function automatic void hist_clear();
        hx.delete();
        hy.delete();
        for (int i = 0; i < 5; i++) begin
            hx.push_back(0);
            hy.push_back(0);
        end
    endfunction

    function automatic void hist_push(input int x, input int y);
        hx.push_front(x);
        hy.push_front(y);
        void'(hx.pop_back());
        void'(hy.pop_back());
    endfunction

    function automatic void update_vel();
        m_vx = floor_div4(hx[0] - hx[4]);
        m_vy = floor_div4(hy[0] - hy[4]);
    endfunction

    function automatic void model_reset();
        m_state = 0; m_cnt = 0; m_miss = 0; m_vx = 0; m_vy = 0;
        hist_clear();
    endfunction

    function automatic out_t model_frame(input int uy, input int lx, input int rx, input int dy);
        out_t e;
        bit   h;
        int   sx, sy;
        h = !(uy == NF || lx == NF || rx < lx || dy < uy || rx - lx < 4 || dy - uy < 4);
        e = '0;
        e.valid = 1'b1;
        e.hit = h;
        sx = clampi(hx[0] + m_vx, 639);
        sy = clampi(hy[0] + m_vy, 479);
        case (m_state)
            0: if (h) begin hist_push((lx + rx) / 2, (uy + dy) / 2); m_cnt = 1; m_state = 1; end
            1: if (h) begin
                   hist_push((lx + rx) / 2, (uy + dy) / 2);
                   m_cnt++;
                   if (m_cnt == 5) begin m_state = 2; update_vel(); end
               end else begin
                   hist_clear(); m_cnt = 0; m_state = 0;
               end
            2: if (h) begin hist_push((lx + rx) / 2, (uy + dy) / 2); update_vel(); end
               else begin hist_push(sx, sy); m_miss = 1; m_state = 3; end
            default: if (h) begin
                   hist_push((lx + rx) / 2, (uy + dy) / 2); m_miss = 0; m_state = 2; update_vel();
               end else if (m_miss + 1 < 8) begin
                   m_miss++; hist_push(sx, sy);
               end else begin
                   hist_clear(); m_vx = 0; m_vy = 0; m_miss = 0; m_cnt = 0; m_state = 0; e.lost = 1'b1;
               end
        endcase
        e.state = 2'(m_state);
        if (m_state != 0) begin
            e.cx = 11'(hx[0]);
            e.cy = 11'(hy[0]);
            e.vx = 12'(m_vx);
            e.vy = 12'(m_vy);
            e.px = 11'(clampi(hx[0] + 2 * m_vx, 639));
            e.py = 11'(clampi(hy[0] + 2 * m_vy, 479));
        end
        return e;
    endfunction

    function automatic out_t sample_out();
        out_t s;
        s.valid = o_valid; s.hit = o_hit; s.cx = o_cx; s.cy = o_cy;
        s.vx = o_vx; s.vy = o_vy; s.px = o_px; s.py = o_py;
        s.state = o_state; s.lost = o_lost;
        return s;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("valid=%0d hit=%0d c=(%0d,%0d) v=(%0d,%0d) p=(%0d,%0d) st=%0d lost=%0d",
                         o.valid, o.hit, o.cx, o.cy, $signed(o.vx), $signed(o.vy),
                         o.px, o.py, o.state, o.lost);
    endfunction

    function automatic void set_frame(input int i, input int uy, input int lx, input int rx, input int dy);
        f_uy[i] = uy; f_lx[i] = lx; f_rx[i] = rx; f_dy[i] = dy;
    endfunction

    function automatic void set_box(input int i, input int cx, input int cy, input int hw, input int hh);
        set_frame(i, cy - hh, cx - hw, cx + hw, cy + hh);
    endfunction

    // frame j is captured at the edge after negedge j; its outputs are seen at negedge j+2
    task automatic run_burst(input int n);
        for (int j = 0; j < n + 2; j++) begin
            @(negedge clk);
            if (j >= 2) got[j-2] = sample_out();
            if (j == 1) early_valid = o_valid;
            if (j < n) begin
                i_up[0] = 11'(f_uy[j]);    i_up[1] = 11'(f_lx[j] + 3);
                i_left[1] = 11'(f_lx[j]);  i_left[0] = 11'(f_uy[j] + 5);
                i_right[1] = 11'(f_rx[j]); i_right[0] = 11'(f_dy[j]);
                i_down[0] = 11'(f_dy[j]);  i_down[1] = 11'(f_rx[j]);
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        i_valid = 1'b0;
        i_up = '0; i_left = '0; i_right = '0; i_down = '0;
        i_rst_n = 1'b1;
        #1 i_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sample_out() !== out_t'(0)) begin
            n_fails++; $display("FAIL reset_outputs: got %s, want all zero", fmt(sample_out()));
        end
        i_rst_n = 1'b1;
        model_reset();
        set_frame(0, NF, 100, 120, 70);
        run_burst(1);
        n_checks++;
        if (early_valid !== 1'b0) begin
            n_fails++; $display("FAIL reset_latency: o_valid one cycle after i_valid got %0d, want 0", early_valid);
        end
        exp_o = model_frame(f_uy[0], f_lx[0], f_rx[0], f_dy[0]);
        n_checks++;
        if (got[0] !== exp_o) begin
            n_fails++; $display("FAIL reset_notfound: got %s, want %s", fmt(got[0]), fmt(exp_o));
        end
        n_checks++;
        if (got[0].valid !== 1'b1 || got[0].hit !== 1'b0 || got[0].state !== 2'd0 || got[0].px !== 11'd0) begin
            n_fails++; $display("FAIL reset_notfound_const: got %s, want valid=1 hit=0 st=0 zeros", fmt(got[0]));
        end
    endtask

    task automatic test_acquire();
        for (int k = 0; k < 5; k++) begin
            set_frame(0, 50, 100 + 4 * k, 120 + 4 * k, 70);
            run_burst(1);
            exp_o = model_frame(f_uy[0], f_lx[0], f_rx[0], f_dy[0]);
            n_checks++;
            if (got[0] !== exp_o) begin
                n_fails++; $display("FAIL acquire[%0d]: got %s, want %s", k, fmt(got[0]), fmt(exp_o));
            end
        end
        n_checks++;
        if (got[0].state !== 2'd2 || got[0].vx !== 12'd4 || got[0].vy !== 12'd0 ||
            got[0].px !== 11'd134 || got[0].cx !== 11'd126) begin
            n_fails++; $display("FAIL acquire_track: got %s, want st=2 c=126 v=(4,0) px=134", fmt(got[0]));
        end
    endtask

    task automatic test_coast();
        for (int k = 0; k < 2; k++) begin
            set_frame(0, NF, 100, 120, 70);
            run_burst(1);
            exp_o = model_frame(f_uy[0], f_lx[0], f_rx[0], f_dy[0]);
            n_checks++;
            if (got[0] !== exp_o) begin
                n_fails++; $display("FAIL coast[%0d]: got %s, want %s", k, fmt(got[0]), fmt(exp_o));
            end
            n_checks++;
            if (got[0].state !== 2'd3 || got[0].cx !== 11'(130 + 4 * k) || got[0].vx !== 12'd4) begin
                n_fails++; $display("FAIL coast_const[%0d]: got %s, want st=3 cx=%0d vx=4", k, fmt(got[0]), 130 + 4 * k);
            end
        end
        set_box(0, 138, 60, 10, 10);
        run_burst(1);
        exp_o = model_frame(f_uy[0], f_lx[0], f_rx[0], f_dy[0]);
        n_checks++;
        if (got[0] !== exp_o || got[0].state !== 2'd2 || got[0].hit !== 1'b1) begin
            n_fails++; $display("FAIL coast_recover: got %s, want %s", fmt(got[0]), fmt(exp_o));
        end
    endtask

    task automatic test_lost();
        for (int k = 0; k < 8; k++) begin
            set_frame(0, 50, NF, 120, 70);
            run_burst(1);
            exp_o = model_frame(f_uy[0], f_lx[0], f_rx[0], f_dy[0]);
            n_checks++;
            if (got[0] !== exp_o) begin
                n_fails++; $display("FAIL lost[%0d]: got %s, want %s", k, fmt(got[0]), fmt(exp_o));
            end
        end
        n_checks++;
        if (got[0].lost !== 1'b1 || got[0].state !== 2'd0 || got[0].vx !== 12'd0 || got[0].cx !== 11'd0) begin
            n_fails++; $display("FAIL lost_final: got %s, want lost=1 st=0 vx=0 cx=0", fmt(got[0]));
        end
    endtask

    task automatic test_clamp();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_box(0, 605 + 8 * k, 105, 2, 5);
            run_burst(1);
            exp_o = model_frame(f_uy[0], f_lx[0], f_rx[0], f_dy[0]);
            n_checks++;
            if (got[0] !== exp_o) begin
                n_fails++; $display("FAIL clamp_hi[%0d]: got %s, want %s", k, fmt(got[0]), fmt(exp_o));
            end
        end
        n_checks++;
        if (got[0].cx !== 11'd637 || got[0].vx !== 12'd8 || got[0].px !== 11'd639) begin
            n_fails++; $display("FAIL clamp_hi_const: got %s, want cx=637 vx=8 px=639", fmt(got[0]));
        end
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_box(0, 35 - 8 * k, 105, 2, 5);
            run_burst(1);
            exp_o = model_frame(f_uy[0], f_lx[0], f_rx[0], f_dy[0]);
            n_checks++;
            if (got[0] !== exp_o) begin
                n_fails++; $display("FAIL clamp_lo[%0d]: got %s, want %s", k, fmt(got[0]), fmt(exp_o));
            end
        end
        n_checks++;
        if (got[0].cx !== 11'd3 || got[0].vx !== 12'hFF8 || got[0].px !== 11'd0) begin
            n_fails++; $display("FAIL clamp_lo_const: got %s, want cx=3 vx=-8 px=0", fmt(got[0]));
        end
    endtask

    task automatic test_acquire_miss();
        do_reset();
        set_box(0, 210, 60, 10, 10);
        set_box(1, 212, 60, 10, 10);
        set_frame(2, 50, 200, 203, 70);
        run_burst(3);
        for (int i = 0; i < 3; i++) begin
            exp_o = model_frame(f_uy[i], f_lx[i], f_rx[i], f_dy[i]);
            n_checks++;
            if (got[i] !== exp_o) begin
                n_fails++; $display("FAIL acq_miss[%0d]: got %s, want %s", i, fmt(got[i]), fmt(exp_o));
            end
        end
        n_checks++;
        if (got[2].hit !== 1'b0 || got[2].state !== 2'd0 || got[2].lost !== 1'b0) begin
            n_fails++; $display("FAIL acq_miss_const: got %s, want hit=0 st=0 lost=0", fmt(got[2]));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) set_box(i, 300 + 5 * i, 200 - 3 * i, 8, 6);
        run_burst(8);
        for (int i = 0; i < 8; i++) begin
            exp_o = model_frame(f_uy[i], f_lx[i], f_rx[i], f_dy[i]);
            n_checks++;
            if (got[i] !== exp_o) begin
                n_fails++; $display("FAIL b2b[%0d]: got %s, want %s", i, fmt(got[i]), fmt(exp_o));
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        set_box(0, 400, 300, 10, 10);
        @(negedge clk);
        i_up[0] = 11'(f_uy[0]); i_left[1] = 11'(f_lx[0]);
        i_right[1] = 11'(f_rx[0]); i_down[0] = 11'(f_dy[0]);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        model_reset();
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen = seen | o_valid;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fails++; $display("FAIL midflight_reset: o_valid seen=%0d, want 0", seen);
        end
    endtask

    task automatic test_random();
        int t_cx, t_cy, t_vx, t_vy, n, pmiss, kind, hw, hh;
        t_cx = 320; t_cy = 240; t_vx = 3; t_vy = -2;
        for (int b = 0; b < 80; b++) begin
            n = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
                0: pmiss = 5;
                1: pmiss = 35;
                default: pmiss = 95;
            endcase
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    t_vx = $urandom_range(0, 40) - 20;
                    t_vy = $urandom_range(0, 30) - 15;
                end
                t_cx = t_cx + t_vx;
                t_cy = t_cy + t_vy;
                if (t_cx < 30 || t_cx > 700) begin t_vx = -t_vx; t_cx = clampi(t_cx, 700); end
                if (t_cy < 30 || t_cy > 520) begin t_vy = -t_vy; t_cy = clampi(t_cy, 520); end
                hw = $urandom_range(2, 20);
                hh = $urandom_range(2, 20);
                set_box(i, t_cx, t_cy, hw, hh);
                if ($urandom_range(0, 99) < pmiss) begin
                    kind = $urandom_range(0, 4);
                    case (kind)
                        0: f_uy[i] = NF;
                        1: f_lx[i] = NF;
                        2: f_rx[i] = f_lx[i] - 1;
                        3: f_rx[i] = f_lx[i] + $urandom_range(0, 3);
                        default: f_dy[i] = f_uy[i] + $urandom_range(0, 3);
                    endcase
                end
            end
            run_burst(n);
            for (int i = 0; i < n; i++) begin
                exp_o = model_frame(f_uy[i], f_lx[i], f_rx[i], f_dy[i]);
                n_checks++;
                if (got[i] !== exp_o) begin
                    n_fails++; $display("FAIL random[%0d.%0d]: got %s, want %s", b, i, fmt(got[i]), fmt(exp_o));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_coast();
        test_lost();
        test_clamp();
        test_acquire_miss();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
